rx_timer: RTL and testbench

RX_TIMER -- requirements
Module: rx_timer

---
 rtl/rx_pkg.sv | 14 +
 rtl/flex_counter.sv | 36 +++
 rtl/rx_timer.sv | 96 +++++++++
 tb/tb_rx_timer.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// Shared constants and FSM state encoding for the serial receive timer.
package rx_pkg;

    localparam int unsigned DEF_CLKS_PER_BIT = 10;
    localparam int unsigned DEF_DATA_BITS    = 8;
    localparam int unsigned BIT_INDEX_W      = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } rx_state_t;

endpackage

// File: rtl/flex_counter.sv
// Rollover counter: counts 0..rollover_val-1 while enabled, flag marks the last value.
module flex_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             count_enable,
    input  logic [WIDTH-1:0] rollover_val,
    output logic [WIDTH-1:0] count_out,
    output logic             rollover_flag
);

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] last_val_c;

    // Next count; wraps to zero after the last value
    always_comb begin
        last_val_c = rollover_val - WIDTH'(1);
        count_d    = count_out;
        if (count_enable) begin
            count_d = (count_out == last_val_c) ? '0 : count_out + WIDTH'(1);
        end
    end

    // Flag is a registered decode so downstream logic sees it with no compare delay
    always_ff @(posedge clk) begin
        if (clear) begin
            count_out     <= '0;
            rollover_flag <= 1'b0;
        end else begin
            count_out     <= count_d;
            rollover_flag <= (count_d == last_val_c);
        end
    end

endmodule

// File: rtl/rx_timer.sv
// Receive bit timer: paces shift strobes across one frame and flags frame completion.
module rx_timer
    import rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int unsigned DATA_BITS    = DEF_DATA_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable_timer,
    output logic                   shift_strobe,
    output logic                   packet_done,
    output logic [BIT_INDEX_W-1:0] bit_index
);

    localparam int unsigned PERIOD_W   = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned FRAME_BITS = DATA_BITS + 1;
    localparam logic [PERIOD_W-1:0]    PERIOD_ROLL = PERIOD_W'(CLKS_PER_BIT);
    localparam logic [BIT_INDEX_W-1:0] BIT_ROLL    = BIT_INDEX_W'(FRAME_BITS + 1);

    rx_state_t state_q;
    rx_state_t state_d;
    logic      strobe_d;
    logic      done_d;
    logic      period_clear_c;
    logic      bit_clear_c;
    logic      period_flag;
    logic      frame_full;

    // The period count value itself is not needed; its flag carries the decode
    logic [PERIOD_W-1:0] period_cnt_unused;

    flex_counter #(.WIDTH(PERIOD_W)) u_period_cnt (
        .clk          (clk),
        .clear        (period_clear_c),
        .count_enable (enable_timer),
        .rollover_val (PERIOD_ROLL),
        .count_out    (period_cnt_unused),
        .rollover_flag(period_flag)
    );

    // Counts strobes; its flag goes high once the stop bit has been strobed
    flex_counter #(.WIDTH(BIT_INDEX_W)) u_bit_cnt (
        .clk          (clk),
        .clear        (bit_clear_c),
        .count_enable (strobe_d),
        .rollover_val (BIT_ROLL),
        .count_out    (bit_index),
        .rollover_flag(frame_full)
    );

    // Next-state and pulse decode; a low enable always wins over a due strobe
    always_comb begin
        state_d  = state_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable_timer) begin
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (!enable_timer) begin
                    state_d = IDLE;
                end else if (frame_full) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (period_flag) begin
                    strobe_d = 1'b1;
                end
            end
            DONE: begin
                if (!enable_timer) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        period_clear_c = rst || (state_d != COUNT);
        bit_clear_c    = rst || (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_strobe <= 1'b0;
            packet_done  <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_strobe <= strobe_d;
            packet_done  <= done_d;
        end
    end

endmodule

// File: tb/tb_rx_timer.sv
// Directed bench for rx_timer: default instance plus a CLKS_PER_BIT=2, DATA_BITS=5 instance.
module tb_rx_timer;

    logic       clk;
    logic       rst0, en0, s0, d0;
    logic       rst1, en1, s1, d1;
    logic [3:0] i0, i1;

    int n_cmp;
    int n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    rx_timer dut0 (
        .clk(clk), .rst(rst0), .enable_timer(en0),
        .shift_strobe(s0), .packet_done(d0), .bit_index(i0)
    );

    rx_timer #(.CLKS_PER_BIT(2), .DATA_BITS(5)) dut1 (
        .clk(clk), .rst(rst1), .enable_timer(en1),
        .shift_strobe(s1), .packet_done(d1), .bit_index(i1)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Cycle k is the period after edge k-1; enable driven in cycle c is sampled at edge c.
    // Enable is high in cycles 1..hi1_e and hi2_s..hi2_e; rst high in cycle rst_cyc (0 = none).
    typedef struct {
        int dut;
        int hi1_e;
        int hi2_s;
        int hi2_e;
        int rst_cyc;
        int len;
        int chk_cyc;
        int exp_idx;
        int exp_n;
        int exp_first;
        int exp_last;
        int exp_nd;
        int exp_ld;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vec_t       v;
        int         n, first, last, nd, ld, ov, idx_seen, k;
        logic       s, d, en, r;
        logic [3:0] ix;

        n_cmp = 0;
        n_bad = 0;
        //          dut  hi1  hi2s hi2e rst  len  chk idx  n  first last nd  ld
        vecs[0] = '{0,   92,  0,   -1,  0,   95,  92,  9,  9, 11,   91,  1,  92};  // nominal
        vecs[1] = '{0,  100,  0,   -1,  0,  105, 101,  9,  9, 11,   91,  1,  92};  // DONE holds
        vecs[2] = '{0,   35,  0,   -1,  0,   45,  37,  0,  3, 11,   31,  0,   0};  // abort
        vecs[3] = '{0,   39,  0,   -1,  0,   45,  41,  0,  3, 11,   31,  0,   0};  // abort on strobe edge
        vecs[4] = '{0,   40,  0,   -1,  0,   45,  41,  4,  4, 11,   41,  0,   0};  // one cycle later
        vecs[5] = '{0,  142,  0,   -1, 50,  150,  51,  0, 13, 11,  141,  1, 142};  // reset mid-frame
        vecs[6] = '{0,   92, 94,  185,  0,  190, 104,  1, 18, 11,  184,  2, 185};  // back-to-back
        vecs[7] = '{0,   35, 37,  140,  0,  145,  37,  0, 12, 11,  127,  1, 128};  // restart after abort
        vecs[8] = '{1,   20,  0,   -1,  0,   25,  14,  6,  6,  3,   13,  1,  14};  // 2 clk/bit, 5 data
        vecs[9] = '{1,    5,  0,   -1,  0,   10,   7,  0,  2,  3,    5,  0,   0};  // small abort on strobe

        // Reset state
        rst0 = 1'b1; rst1 = 1'b1; en0 = 1'b0; en1 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_strobe0", int'(s0), 0);
        check("rst_done0",   int'(d0), 0);
        check("rst_idx0",    int'(i0), 0);
        check("rst_strobe1", int'(s1), 0);
        check("rst_done1",   int'(d1), 0);
        check("rst_idx1",    int'(i1), 0);
        rst0 = 1'b0; rst1 = 1'b0;
        repeat (2) @(negedge clk);

        for (int vi = 0; vi < 10; vi++) begin
            v = vecs[vi];
            n = 0; first = 0; last = 0; nd = 0; ld = 0; ov = 0; idx_seen = -1;
            for (int c = 1; c <= v.len; c++) begin
                @(negedge clk);
                en = (c <= v.hi1_e) || (c >= v.hi2_s && c <= v.hi2_e);
                r  = (c == v.rst_cyc);
                if (v.dut == 0) begin en0 = en; rst0 = r; end
                else            begin en1 = en; rst1 = r; end
                @(posedge clk);
                #1;
                k  = c + 1;
                s  = (v.dut == 0) ? s0 : s1;
                d  = (v.dut == 0) ? d0 : d1;
                ix = (v.dut == 0) ? i0 : i1;
                if (s) begin
                    n++;
                    if (first == 0) first = k;
                    last = k;
                end
                if (d) begin
                    nd++;
                    ld = k;
                end
                if (s && d) ov++;
                if (k == v.chk_cyc) idx_seen = int'(ix);
            end
            @(negedge clk);
            en0 = 1'b0; en1 = 1'b0; rst0 = 1'b0; rst1 = 1'b0;
            repeat (3) @(negedge clk);
            check($sformatf("v%0d_n_strobe", vi),     n,        v.exp_n);
            check($sformatf("v%0d_first_strobe", vi), first,    v.exp_first);
            check($sformatf("v%0d_last_strobe", vi),  last,     v.exp_last);
            check($sformatf("v%0d_n_done", vi),       nd,       v.exp_nd);
            check($sformatf("v%0d_done_cycle", vi),   ld,       v.exp_ld);
            check($sformatf("v%0d_bit_index", vi),    idx_seen, v.exp_idx);
            check($sformatf("v%0d_overlap", vi),      ov,       0);
        end

        // Reset while in DONE, then a fresh frame must restart from enabled cycle 1
        n = 0; first = 0;
        for (int c = 1; c <= 105; c++) begin
            @(negedge clk);
            en0  = 1'b1;
            rst0 = (c == 93);
            @(posedge clk);
            #1;
            if (c == 92) check("done_idx_before_rst", int'(i0), 9);
            if (c == 93) begin
                check("post_rst_strobe", int'(s0), 0);
                check("post_rst_done",   int'(d0), 0);
                check("post_rst_idx",    int'(i0), 0);
            end
            if (c > 93 && s0) begin
                n++;
                if (first == 0) first = c + 1;
            end
        end
        @(negedge clk);
        en0 = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_n_strobe", n, 1);
        check("post_rst_first",    first, 104);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
